// File: rtl/sprite_streamer.sv
// ---------------------------------------------------------------------------
// sprite_streamer
//
// Reads one SPRITE_DIM x SPRITE_DIM sprite from the sprite ROM and
// serializes it as a row-major stream of 1-bit pixels with valid/ready flow
// control. Each request snapshots the whole sprite into a shadow register,
// so the ROM is owned for only two cycles (WAIT, LOAD). An optional
// horizontal flip is applied while streaming.
//
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   req_valid/req_ready   request handshake; req_sprite selects the sprite,
//                         req_flip mirrors it horizontally
//   abort                 cancel the current request or stream
//   rom_addr, rom_data    sprite ROM read port; rom_data is flat, bit
//                         (row*SPRITE_DIM + col), valid one cycle after addr
//   rom_busy              block owns the ROM address port (WAIT and LOAD)
//   px_valid/px_ready     pixel beat handshake
//   px_data               pixel value
//   px_x, px_y            logical (unflipped) column/row of the beat
//   px_eol, px_last       last column of the row / final pixel of the sprite
// ---------------------------------------------------------------------------
module sprite_streamer #(
    parameter int SPRITE_DIM = 19,
    parameter int IDX_W      = 5,
    parameter int CNT_W      = 5
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic [IDX_W-1:0]                 req_sprite,
    input  logic                             req_flip,
    input  logic                             abort,
    output logic [IDX_W-1:0]                 rom_addr,
    input  logic [SPRITE_DIM*SPRITE_DIM-1:0] rom_data,
    output logic                             rom_busy,
    output logic                             px_valid,
    input  logic                             px_ready,
    output logic                             px_data,
    output logic [CNT_W-1:0]                 px_x,
    output logic [CNT_W-1:0]                 px_y,
    output logic                             px_eol,
    output logic                             px_last
);

    localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(SPRITE_DIM - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_LOAD,
        S_STREAM
    } state_t;

    state_t state_q, state_d;

    logic                             rst_done_q;
    logic [IDX_W-1:0]                 rom_addr_q;
    logic                             flip_q;
    logic [SPRITE_DIM*SPRITE_DIM-1:0] shadow_q;
    logic [CNT_W-1:0]                 x_q, x_d;
    logic [CNT_W-1:0]                 y_q, y_d;

    logic accept;
    logic xfer;

    // ---------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------
    // FSM: next-state logic
    // ---------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (accept) state_d = S_WAIT;
            S_WAIT:   state_d = S_LOAD;
            S_LOAD:   state_d = S_STREAM;
            S_STREAM: if (xfer && x_q == LAST_POS && y_q == LAST_POS) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        // Abort wins from every state; a coincident beat still transfers.
        if (abort) state_d = S_IDLE;
    end

    // ---------------------------------------------------------------
    // FSM: outputs
    // ---------------------------------------------------------------
    always_comb begin
        // rst_done_q keeps req_ready low until reset_n has been sampled high.
        req_ready = rst_done_q && (state_q == S_IDLE) && !abort;
        rom_busy  = (state_q == S_WAIT) || (state_q == S_LOAD);
        px_valid  = (state_q == S_STREAM);
        accept    = req_valid && req_ready;
        xfer      = px_valid && px_ready;
    end

    // ---------------------------------------------------------------
    // Pixel select: split the shadow into rows, then pick the column.
    // ---------------------------------------------------------------
    logic [SPRITE_DIM-1:0] shadow_row [SPRITE_DIM];

    for (genvar gi = 0; gi < SPRITE_DIM; gi++) begin : g_rows
        assign shadow_row[gi] = shadow_q[gi*SPRITE_DIM +: SPRITE_DIM];
    end

    logic [SPRITE_DIM-1:0] row_sel;
    logic [CNT_W-1:0]      col_sel;

    always_comb begin
        row_sel = shadow_row[y_q];
        // Flip mirrors only the fetched column; px_x still reports x_q.
        col_sel = flip_q ? (LAST_POS - x_q) : x_q;
        px_data = px_valid && row_sel[col_sel];
        px_eol  = px_valid && (x_q == LAST_POS);
        px_last = px_eol && (y_q == LAST_POS);
        px_x    = x_q;
        px_y    = y_q;
        rom_addr = rom_addr_q;
    end

    // ---------------------------------------------------------------
    // Raster counters
    // ---------------------------------------------------------------
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (state_q == S_LOAD) begin
            x_d = '0;
            y_d = '0;
        end else if (xfer) begin
            if (x_q == LAST_POS) begin
                x_d = '0;
                // Wrap y after the final beat so the idle position is (0,0).
                y_d = (y_q == LAST_POS) ? '0 : y_q + CNT_W'(1);
            end else begin
                x_d = x_q + CNT_W'(1);
            end
        end
    end

    // ---------------------------------------------------------------
    // Datapath registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rst_done_q <= 1'b0;
            rom_addr_q <= '0;
            flip_q     <= 1'b0;
            shadow_q   <= '0;
            x_q        <= '0;
            y_q        <= '0;
        end else begin
            rst_done_q <= 1'b1;
            x_q        <= x_d;
            y_q        <= y_d;
            if (accept) begin
                rom_addr_q <= req_sprite;
                flip_q     <= req_flip;
            end
            // Snapshot: later ROM writes cannot disturb the stream.
            if (state_q == S_LOAD) begin
                shadow_q <= rom_data;
            end
        end
    end

endmodule

// File: tb/tb_sprite_streamer.sv
// ---------------------------------------------------------------------------
// tb_sprite_streamer
//
// Scoreboard bench: each accepted request pushes its 361 expected beats
// (computed from a snapshot of the bench's own ROM array) into a queue; a
// monitor pops and compares on every transfer. Directed tasks cover timing,
// flip, random back-pressure, abort, ROM-clear-after-load and reset.
// ---------------------------------------------------------------------------
module tb_sprite_streamer;

    localparam int D = 19;
    localparam int N = D * D;

    typedef logic [12:0] beat_t;   // {data, x[4:0], y[4:0], eol, last}

    logic         clk = 1'b0;
    logic         reset_n;
    logic         req_valid;
    logic         req_ready;
    logic [4:0]   req_sprite;
    logic         req_flip;
    logic         abort;
    logic [4:0]   rom_addr;
    logic [N-1:0] rom_data;
    logic         rom_busy;
    logic         px_valid;
    logic         px_ready;
    logic         px_data;
    logic [4:0]   px_x;
    logic [4:0]   px_y;
    logic         px_eol;
    logic         px_last;

    always #5 clk = ~clk;

    sprite_streamer #(.SPRITE_DIM(19), .IDX_W(5), .CNT_W(5)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_sprite(req_sprite),
        .req_flip  (req_flip),
        .abort     (abort),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .rom_busy  (rom_busy),
        .px_valid  (px_valid),
        .px_ready  (px_ready),
        .px_data   (px_data),
        .px_x      (px_x),
        .px_y      (px_y),
        .px_eol    (px_eol),
        .px_last   (px_last)
    );

    // Sprite ROM model: registered read, flat [row*19+col] layout.
    logic [N-1:0] rom_mem [32];
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    int    errors = 0;
    int    checks = 0;
    beat_t exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: row-major walk, flip picks column 18-x.
    task automatic push_expect(input int s, input bit f);
        for (int y = 0; y < D; y++) begin
            for (int x = 0; x < D; x++) begin
                int    col;
                beat_t b;
                col = f ? (D - 1 - x) : x;
                b   = {rom_mem[s][y*D + col], 5'(x), 5'(y), 1'(x == D-1), 1'(x == D-1 && y == D-1)};
                exp_q.push_back(b);
            end
        end
    endtask

    // ---------------------------------------------------------------
    // Monitor
    // ---------------------------------------------------------------
    bit    mon_en = 0;
    bit    stall_have = 0;
    beat_t stall_val;
    beat_t cur;
    beat_t expb;
    int    xfer_cnt = 0;
    int    eol_cnt = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            cur = {px_data, px_x, px_y, px_eol, px_last};
            if (!px_valid) begin
                chk("idle_flags", {px_eol, px_last}, 2'b00);
                stall_have = 0;
            end else begin
                if (stall_have) chk("stall_hold", cur, stall_val);
                if (px_ready) begin
                    xfer_cnt++;
                    if (px_eol) eol_cnt++;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", exp_q.size(), 1);
                    end else begin
                        expb = exp_q.pop_front();
                        chk($sformatf("beat(%0d,%0d)", expb[6:2], expb[11:7]), cur, expb);
                    end
                    stall_have = 0;
                end else begin
                    stall_have = 1;
                    stall_val  = cur;
                end
            end
        end
    end

    // ---------------------------------------------------------------
    // Stimulus helpers
    // ---------------------------------------------------------------
    // Call at a negedge; request is accepted at the following posedge.
    task automatic request(input int s, input bit f);
        int n = 0;
        while (!req_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("req_ready_timeout", req_ready, 1);
        push_expect(s, f);
        req_valid  = 1'b1;
        req_sprite = 5'(s);
        req_flip   = f;
        @(posedge clk);
        #1 req_valid = 1'b0;
        $display("request sprite=%0d flip=%0d accepted at %0t", s, f, $time);
    endtask

    // Cycle-exact check of a full-throughput stream, k = cycles after c0.
    task automatic timed_stream(input bit clear3);
        int busy_bad = 0;
        int last_cnt = 0;
        for (int k = 1; k <= 364; k++) begin
            @(negedge clk);
            if (k == 1 || k == 2) chk($sformatf("busy_c%0d", k), {rom_busy, px_valid}, 2'b10);
            else busy_bad += int'(rom_busy);
            if (k == 3) chk("first_beat_c3", {px_valid, px_x, px_y}, {1'b1, 10'd0});
            if (px_last) last_cnt++;
            if (k == 363) chk("last_beat_c363", {px_last, req_ready}, 2'b10);
            if (k == 364) chk("ready_c364", {req_ready, px_valid}, 2'b10);
            if (clear3 && k == 5) rom_mem[3] = '0;   // loader clears after LOAD
        end
        chk("busy_in_stream", busy_bad, 0);
        chk("last_count", last_cnt, 1);
        chk("queue_drained", exp_q.size(), 0);
    endtask

    task automatic wait_drain(input int max);
        int n = 0;
        while ((exp_q.size() != 0 || px_valid) && n < max) begin
            @(negedge clk);
            n++;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    // Returns at the negedge where beat (x,y) is presented.
    task automatic wait_beat(input int x, input int y);
        int n = 0;
        @(negedge clk);
        while (!(px_valid && px_x == 5'(x) && px_y == 5'(y)) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("reach_beat(%0d,%0d)", x, y), {px_valid, px_x, px_y}, {1'b1, 5'(x), 5'(y)});
    endtask

    task automatic chk_reset(input string tag);
        chk(tag, {req_ready, px_valid, rom_busy, rom_addr, px_x, px_y, px_data, px_eol, px_last}, 21'd0);
    endtask

    logic [N-1:0] diag;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_x, base_e, n;
        reset_n = 1'b0; req_valid = 1'b0; req_sprite = '0; req_flip = 1'b0;
        abort = 1'b0; px_ready = 1'b1;

        for (int s = 0; s < 32; s++)
            for (int b = 0; b < N; b++) rom_mem[s][b] = 1'($urandom_range(0, 1));
        diag = '0;
        for (int r = 0; r < D; r++) diag[r*D + r] = 1'b1;
        rom_mem[3] = diag;
        rom_mem[7] = '1;

        // Power-on reset
        repeat (3) @(posedge clk);
        #1 chk_reset("reset_outputs");
        reset_n = 1'b1;
        @(negedge clk) chk("ready_before_sample", req_ready, 0);
        @(negedge clk) chk("ready_after_reset", req_ready, 1);
        mon_en = 1;

        // Diagonal, no flip; loader clears sprite 3 once streaming
        request(3, 0);
        timed_stream(1);
        rom_mem[3] = diag;

        // Diagonal, flipped, issued back-to-back in c364
        request(3, 1);
        timed_stream(0);

        // All-ones sprite with random back-pressure
        base_x = xfer_cnt; base_e = eol_cnt;
        px_ready = 1'b0;
        request(7, 0);
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(posedge clk);
            #1 px_ready = 1'($urandom_range(0, 1));
            n++;
        end
        px_ready = 1'b1;
        wait_drain(100);
        chk("rand_xfers", xfer_cnt - base_x, 361);
        chk("rand_eols", eol_cnt - base_e, 19);

        // Abort at beat (5,2) with px_ready high
        @(negedge clk);
        request(1, 0);
        wait_beat(5, 2);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        chk("abort_remaining", exp_q.size(), 361 - (2*D + 6));
        exp_q.delete();
        @(negedge clk);
        chk("abort_drop", {px_valid, req_ready}, 2'b01);
        request(1, 1);
        @(negedge clk) chk("abort_reaccept", rom_busy, 1);
        wait_drain(500);

        // Abort together with req_valid in IDLE: nothing accepted
        @(negedge clk);
        abort = 1'b1; req_valid = 1'b1; req_sprite = 5'd3; req_flip = 1'b0;
        #1 chk("abort_blocks_ready", req_ready, 0);
        @(posedge clk);
        #1 begin abort = 1'b0; req_valid = 1'b0; end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk) chk("abort_no_accept", {rom_busy, px_valid}, 2'b00);
        end

        // One-cycle reset at beat (10,10)
        @(negedge clk);
        request(3, 0);
        wait_beat(10, 10);
        reset_n = 1'b0;
        @(posedge clk);
        #1 chk_reset("midstream_reset");
        exp_q.delete();
        reset_n = 1'b1;
        @(negedge clk) chk("rst_ready_low", req_ready, 0);
        @(negedge clk) chk("rst_ready_rise", req_ready, 1);
        request(3, 0);
        timed_stream(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
